// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_WIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles stream bytes little-endian into one instruction word.
module byte_packer
    import loader_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 push,
    input  logic [BYTE_WIDTH-1:0]                byte_in,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] word,
    output logic                                 word_full
);

    logic [1:0] cnt;

    // High while the byte being pushed this cycle completes the word.
    assign word_full = push && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (clear) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (push) begin
            word[cnt*BYTE_WIDTH +: BYTE_WIDTH] <= byte_in;
            cnt                                <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a byte stream into instruction memory as 32-bit words, holding the
// core until the requested number of words has been written.
//
// state | meaning
// IDLE  | out of reset, no load finished yet, core held
// RECV  | accepting bytes of the current word
// WRITE | one-cycle write of the assembled word
// DONE  | load complete, core released
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-2:0] num_words,
    input  logic [BYTE_WIDTH-1:0]    byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    checksum
);

    localparam int IDX_W = ADDRESS_WIDTH - 1;
    // Memory holds 2^(ADDRESS_WIDTH-2) words; larger requests saturate so the
    // address never wraps.
    localparam logic [IDX_W-1:0] MAX_WORDS = {1'b1, {(ADDRESS_WIDTH-2){1'b0}}};

    loader_state_t    state;
    logic [IDX_W-1:0] n_words;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] index_next;
    logic             start_ok;
    logic             push;
    logic             word_full;
    logic [DATA_WIDTH-1:0] word;

    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign push       = byte_valid && (state == RECV);
    assign index_next = index + {{(IDX_W-1){1'b0}}, 1'b1};

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .push      (push),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            n_words  <= '0;
            index    <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        n_words  <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                        index    <= '0;
                        checksum <= '0;
                        state    <= (num_words == '0) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (word_full) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    checksum <= checksum ^ word;
                    index    <= index_next;
                    state    <= (index_next == n_words) ? DONE : RECV;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state == RECV);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = {index[ADDRESS_WIDTH-3:0], 2'b00};
    assign mem_wdata  = word;
    assign cpu_hold   = (state != DONE);
    assign done       = (state == DONE);

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills instruction memory from a byte stream before the core runs. Accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit instruction words. Writes each word into the instruction-memory write port at consecutive word-aligned byte addresses starting at 0. Holds the core while loading; instruction fetch reads only after `done`.

## Interface
- `ADDRESS_WIDTH`, 8, byte-address width of instruction memory (same PC width as fetch)
- `DATA_WIDTH`, 32, instruction word width; fixed at 32 (4 bytes/word)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle pulse, begins a load; sampled only in IDLE or DONE
- `num_words`  in  ADDRESS_WIDTH-1  words to load, latched on accepted `start`
- `byte_in`  in  8  stream byte
- `byte_valid`  in  1  `byte_in` valid
- `byte_ready`  out  1  loader can accept a byte
- `mem_we`  out  1  instruction-memory write enable
- `mem_addr`  out  ADDRESS_WIDTH  byte address, always multiple of 4
- `mem_wdata`  out  DATA_WIDTH  instruction word
- `cpu_hold`  out  1  core must not advance PC
- `done`  out  1  load complete, sticky until next accepted `start`
- `checksum`  out  DATA_WIDTH  XOR of all words written in current/last load

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: `start`=1 → latch `n = min(num_words, 2^(ADDRESS_WIDTH-2))`, clear word index, byte counter, checksum, `done`. Go to DONE if n=0, else RECV.
- RECV: `byte_ready`=1. Byte transfers when `byte_valid && byte_ready` at a rising edge. Byte k of a word (k=0..3) goes into bits [8k+7:8k]. After the 4th transfer → WRITE.
- WRITE: `mem_we`=1 for exactly one cycle with `mem_addr = 4*index` and `mem_wdata` = packed word. `checksum ^= word`. `index++`. Go to DONE if index reaches n, else RECV.
- DONE: `done`=1, `cpu_hold`=0. `start`=1 → same as IDLE.
- `cpu_hold` = 1 in RECV and WRITE, and in IDLE after reset until the first load completes. Core never runs on unloaded memory.
- `start` in RECV/WRITE: ignored.
- `byte_valid` while `byte_ready`=0: no transfer. Byte is not consumed; upstream holds it.
- Reset mid-load (`rst`=0): returns to IDLE. Partially assembled word discarded, no write issued. Already-written words remain in memory.
- Address never wraps: saturation of n bounds the last write to `2^ADDRESS_WIDTH - 4`.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `checksum`=0, state IDLE.
- All outputs registered or decoded from registered state only. No combinational path from inputs to outputs.
- `start` accepted at edge t → `byte_ready`=1 from t+1.
- 4th byte accepted at edge t → `mem_we`=1 during cycle t+1.
- Next `byte_ready`=1 from t+2. Minimum 5 cycles per word with continuous `byte_valid`.
- Last write cycle ends at edge e → `done`=1 and `cpu_hold`=0 from e.
- `checksum` updates at the same edge that ends the write cycle.

## Structure
- Shared package `loader_pkg` holds:
  - state enum `loader_state_t` {IDLE, RECV, WRITE, DONE}
  - `BYTES_PER_WORD` = 4
  - `BYTE_WIDTH` = 8
- Sub-module `byte_packer` owns the 2-bit byte counter and the 32-bit shift/insert register. Ports: `clk`, `rst`, `clear`, `push`, `byte_in`, `word`, `word_full`. Top holds the FSM, index/address counter, checksum.

## Test plan
- Reset then `start`, `num_words`=2, bytes 13,00,00,00,93,00,50,00 back-to-back → write 0x00000013 @0, 0x00500093 @4. `checksum`=0x00500080, `done`=1, `cpu_hold`=0.
- `num_words`=0 → DONE next cycle, `mem_we` never asserted, `checksum`=0.
- `byte_valid` toggling 1/0 every cycle, 1 word AA,BB,CC,DD → single write 0xDDCCBBAA @0. No byte lost or duplicated.
- `num_words`=100 with `ADDRESS_WIDTH`=8 → exactly 64 writes, last @0xFC, then `done`.
- `rst`=0 after 2 bytes of word 1 (word 0 written) → no further write, IDLE, `cpu_hold`=1. Reload of 1 word writes @0.
- Second `start` pulsed during RECV → ignored, count unchanged. `start` in DONE → new load, `done` clears next cycle.
